// File: rtl/mips_cpu_mem_access.sv
// mips_cpu_mem_access: data-memory access unit issuing one Avalon-MM transaction per load/store,
// with lane selection, store replication, load extraction/extension and a CPU stall.
module mips_cpu_mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [1:0]        size_i,
    input  logic              signed_byte_i,
    input  logic [ADDR_W-1:0] eff_addr_i,
    input  logic [31:0]       store_data_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       load_data_o,
    output logic              access_err_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    output logic [3:0]        avm_byteenable_o,
    output logic [31:0]       avm_writedata_o,
    input  logic [31:0]       avm_readdata_i,
    input  logic              avm_waitrequest_i
);
    localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2;

    logic [1:0]        state_q, state_d, off_q, off_d, size_q, size_d;
    logic              rd_q, rd_d, sgn_q, sgn_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wd_q, wd_d, ld_q, ld_d, ext;
    logic [15:0]       lane_h;
    logic [7:0]        lane_b;
    logic              req, illegal;

    assign req     = mem_read_i | mem_write_i;
    assign illegal = (mem_read_i & mem_write_i) | (size_i == 2'b11)
                   | (size_i == 2'b00 && eff_addr_i[1:0] != 2'b00)
                   | (size_i == 2'b01 && eff_addr_i[0]);

    // Extraction uses the offset captured at request time, not the live address.
    assign lane_b = avm_readdata_i[{off_q, 3'b000} +: 8];
    assign lane_h = off_q[1] ? avm_readdata_i[31:16] : avm_readdata_i[15:0];
    assign ext    = size_q == 2'b00 ? avm_readdata_i
                  : size_q == 2'b01 ? {{16{sgn_q & lane_h[15]}}, lane_h}
                  : {{24{sgn_q & lane_b[7]}}, lane_b};

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        rd_d    = rd_q;
        sgn_d   = sgn_q;
        err_d   = err_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        ld_d    = ld_q;
        case (state_q)
            IDLE: if (req) begin
                err_d   = illegal;
                state_d = illegal ? DONE : BUS;
                if (!illegal) begin
                    addr_d = {eff_addr_i[ADDR_W-1:2], 2'b00};
                    off_d  = eff_addr_i[1:0];
                    size_d = size_i;
                    sgn_d  = signed_byte_i;
                    rd_d   = mem_read_i;
                    be_d   = size_i == 2'b00 ? 4'b1111
                           : size_i == 2'b01 ? (eff_addr_i[1] ? 4'b1100 : 4'b0011)
                           : 4'b0001 << eff_addr_i[1:0];
                    wd_d   = size_i == 2'b00 ? store_data_i
                           : size_i == 2'b01 ? {2{store_data_i[15:0]}}
                           : {4{store_data_i[7:0]}};
                end
            end
            BUS: if (!avm_waitrequest_i) begin
                state_d = DONE;
                ld_d    = rd_q ? ext : ld_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            off_q   <= '0;
            size_q  <= '0;
            rd_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            rd_q    <= rd_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            ld_q    <= ld_d;
        end
    end

    assign stall_o          = (state_q == IDLE && req) || state_q == BUS;
    assign done_o           = state_q == DONE;
    assign access_err_o     = state_q == DONE && err_q;
    assign load_data_o      = ld_q;
    assign avm_address_o    = addr_q;
    assign avm_read_o       = state_q == BUS && rd_q;
    assign avm_write_o      = state_q == BUS && !rd_q;
    assign avm_byteenable_o = be_q;
    assign avm_writedata_o  = wd_q;
endmodule
